fsab_rr_arbiter: RTL
====================

Name: fsab_rr_arbiter

Overview:
- Parametrised N-device front end for the FSAB bus.
- Buffers credit-flow-controlled request/data beats from NDEV masters in per-device beat FIFOs.
- Selects whole packets round-robin and forwards them, one packet at a time, onto a single downstream FSAB port gated by downstream credits.
- Successor to the fixed 4-credit single-port RFIF/DFIF front end: packet-atomic, fair, width- and depth-generic.

Parameters:
NDEV, 4, number of upstream devices (1..16)
DEV_CREDITS, 2, packets each device may have outstanding in its FIFO
LEN_MAX, 8, maximum beats per write packet
DN_CREDITS, 4, initial downstream credit count
FIFO_DEPTH, DEV_CREDITS*LEN_MAX, beats per device FIFO (power of two required)

Ports:
clk  in  1  clock
Nrst  in  1  synchronous active-low reset
fsabo_valids  in  NDEV  per-device beat valid
fsabo_modes  in  NDEV*FSAB_REQ_W  per-device mode (meaningful on header beat)
fsabo_dids  in  NDEV*FSAB_DID_W  device id
fsabo_subdids  in  NDEV*FSAB_DID_W  sub-device id
fsabo_addrs  in  NDEV*FSAB_ADDR_W  address
fsabo_lens  in  NDEV*FSAB_LEN_W  beat count
fsabo_datas  in  NDEV*FSAB_DATA_W  data
fsabo_masks  in  NDEV*FSAB_MASK_W  byte mask
fsabo_credits  out  NDEV  one-cycle credit return pulse per device
fsabo_valid, fsabo_mode, fsabo_did, fsabo_subdid, fsabo_addr, fsabo_len, fsabo_data, fsabo_mask  out  (1, FSAB_*_W each)  downstream beat
fsabo_credit  in  1  downstream credit return pulse
ovf_err  out  NDEV  sticky: beat written while FIFO full

Behaviour:
- Reset is synchronous, active-low, single clock:
  - FIFOs emptied, FSM to IDLE, rr pointer 0, downstream credit count = DN_CREDITS.
  - All outputs 0; ovf_err cleared.
  - A reset mid-packet aborts the packet silently; devices must reset their credits too.
- Packet framing, tracked by a per-device input framer:
  - First valid beat after packet end is the header; it carries mode/did/subdid/addr/len plus the first data word.
  - WRITE packet = max(len,1) beats; any other mode = 1 beat.
  - Framer tags each FIFO entry with sof/eof.
- Device FIFO:
  - Write on fsabo_valids[i]; a write when full is dropped and sets ovf_err[i].
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full = MSB differs and low bits equal.
- FSM IDLE:
  - Eligible set = devices whose FIFO head is non-empty with sof=1.
  - Grant requires downstream count > 0.
  - Winner = first eligible index searching upward (with wrap) from rr pointer.
  - On grant: pop head, register onto outputs (valid next cycle), decrement downstream count, store grant index; go XFER, or stay IDLE if the head is also eof.
- FSM XFER:
  - Each cycle the granted FIFO is non-empty: pop and forward one beat.
  - If it is empty: fsabo_valid=0 (bubble); grant held.
  - On the eof beat: pulse fsabo_credits[grant] in the same cycle the beat is output, set rr pointer = grant+1 mod NDEV, return to IDLE.
  - Other devices are never interleaved.
- Latency:
  - Beat written at cycle t → FIFO non-empty at t+1 → earliest fsabo_valid at t+2.
  - Back-to-back packets have one IDLE cycle between them.
- Downstream credits:
  - fsabo_credit increments the count; simultaneous grant and credit leaves it unchanged.
  - Count saturates at DN_CREDITS.
  - Count 0 blocks new grants only; a packet in flight completes.
- Non-header outputs (mode/did/...) hold the header values for the whole packet; they are 0 when idle.

Optional Feature:
FSAB_ARB_STATS_EN
- Defined: adds output stat_grants (NDEV*16, per-device packets granted, wrapping) and stat_stalls (16, cycles with eligible devices but downstream count 0, saturating). Both are cleared by reset.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Package fsab_pkg holds:
  - field widths: FSAB_REQ_W, FSAB_DID_W, FSAB_ADDR_W, FSAB_LEN_W, FSAB_DATA_W, FSAB_MASK_W
  - FSAB_WRITE / FSAB_READ mode encodings
  - beat-entry struct {sof, eof, header, data, mask}
  - FSAB_DEVICES_MAX = 16
- One sub-module, fsab_arb_fifo: synchronous FIFO with framer, full/empty, overflow flag. Instantiated NDEV times via generate.

Test Plan:
- Single read, device 0: one beat at t → fsabo_valid at t+2 with matching header; fsabo_credits[0] pulses the same cycle; downstream count 4→3.
- Write, len=4, from device 2 while device 1 issues a read in the same cycle (rr=0) → device 1 read first, then four contiguous device-2 beats with no interleave; rr ends at 3.
- All 4 devices continuously request → grant order 0,1,2,3,0 with exactly one idle cycle between packets.
- DN_CREDITS=1, two pending packets → second waits until a fsabo_credit pulse; a credit arriving on the grant cycle keeps the count at 1.
- Device writes FIFO_DEPTH+1 beats with the output blocked → last beat dropped, ovf_err set sticky until Nrst low.
- Nrst asserted mid write packet (beat 2 of 4) → next cycle all outputs 0, FIFOs empty, count = DN_CREDITS; a new packet after reset is forwarded normally.

Source files
------------

// File: rtl/fsab_pkg.sv
// FSAB bus field widths, mode encodings and the beat entry stored in the device FIFOs.
package fsab_pkg;

  localparam int unsigned FSAB_REQ_W       = 3;
  localparam int unsigned FSAB_DID_W       = 4;
  localparam int unsigned FSAB_ADDR_W      = 32;
  localparam int unsigned FSAB_LEN_W       = 4;
  localparam int unsigned FSAB_DATA_W      = 64;
  localparam int unsigned FSAB_MASK_W      = 8;
  localparam int unsigned FSAB_DEVICES_MAX = 16;

  localparam logic [FSAB_REQ_W-1:0] FSAB_READ  = 3'd0;
  localparam logic [FSAB_REQ_W-1:0] FSAB_WRITE = 3'd1;

  typedef struct packed {
    logic [FSAB_REQ_W-1:0]  mode;
    logic [FSAB_DID_W-1:0]  did;
    logic [FSAB_DID_W-1:0]  subdid;
    logic [FSAB_ADDR_W-1:0] addr;
    logic [FSAB_LEN_W-1:0]  len;
  } fsab_hdr_t;

  typedef struct packed {
    logic                   sof;
    logic                   eof;
    fsab_hdr_t              header;
    logic [FSAB_DATA_W-1:0] data;
    logic [FSAB_MASK_W-1:0] mask;
  } fsab_beat_t;

  // Beats in a packet: writes carry max(len,1) beats, everything else is a single beat.
  function automatic logic [FSAB_LEN_W-1:0] fsab_pkt_beats(input logic [FSAB_REQ_W-1:0] mode,
                                                            input logic [FSAB_LEN_W-1:0] len);
    if ((mode == FSAB_WRITE) && (len > FSAB_LEN_W'(1))) return len;
    return FSAB_LEN_W'(1);
  endfunction

endpackage

// File: rtl/fsab_arb_fifo.sv
// Per-device beat FIFO with an input framer that tags each entry with sof/eof.
module fsab_arb_fifo
  import fsab_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                   clk,
  input  logic                   Nrst,
  input  logic                   wr_valid,
  input  fsab_hdr_t              wr_header,
  input  logic [FSAB_DATA_W-1:0] wr_data,
  input  logic [FSAB_MASK_W-1:0] wr_mask,
  input  logic                   rd_pop,
  output fsab_beat_t             head,
  output logic                   empty,
  output logic                   ovf_err
);

  localparam int unsigned AW = $clog2(Depth);

  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  fsab_beat_t           mem_q [Depth];
  logic                 full;
  logic                 in_pkt_q, in_pkt_d;
  logic [FSAB_LEN_W-1:0] remain_q, remain_d;
  logic [FSAB_LEN_W-1:0] n_beats;
  fsab_beat_t           wr_beat;
  logic                 ovf_q;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign ovf_err = ovf_q;

  always_comb begin
    n_beats        = fsab_pkt_beats(wr_header.mode, wr_header.len);
    wr_beat.sof    = !in_pkt_q;
    wr_beat.eof    = in_pkt_q ? (remain_q == FSAB_LEN_W'(1)) : (n_beats == FSAB_LEN_W'(1));
    wr_beat.header = wr_header;
    wr_beat.data   = wr_data;
    wr_beat.mask   = wr_mask;
    in_pkt_d       = in_pkt_q;
    remain_d       = remain_q;
    if (!in_pkt_q) begin
      if (n_beats != FSAB_LEN_W'(1)) begin
        in_pkt_d = 1'b1;
        remain_d = n_beats - 1'b1;
      end
    end else begin
      remain_d = remain_q - 1'b1;
      if (remain_q == FSAB_LEN_W'(1)) in_pkt_d = 1'b0;
    end
  end

  // Framer follows the device's view of framing even when a beat is dropped.
  always_ff @(posedge clk) begin
    if (!Nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      in_pkt_q <= 1'b0;
      remain_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_valid) begin
        in_pkt_q <= in_pkt_d;
        remain_q <= remain_d;
      end
      if (wr_valid && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (wr_valid && full) ovf_q <= 1'b1;
      if (rd_pop && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_valid && !full) mem_q[wr_ptr_q[AW-1:0]] <= wr_beat;
  end

endmodule

// File: rtl/fsab_rr_arbiter.sv
// N-device FSAB front end: packet-atomic round-robin onto one credit-gated downstream port.
// Optional statistics counters are enabled with FSAB_ARB_STATS_EN.
module fsab_rr_arbiter
  import fsab_pkg::*;
#(
  parameter int unsigned NDEV        = 4,
  parameter int unsigned DEV_CREDITS = 2,
  parameter int unsigned LEN_MAX     = 8,
  parameter int unsigned DN_CREDITS  = 4,
  parameter int unsigned FIFO_DEPTH  = DEV_CREDITS * LEN_MAX
) (
  input  logic                        clk,
  input  logic                        Nrst,
  input  logic [NDEV-1:0]             fsabo_valids,
  input  logic [NDEV*FSAB_REQ_W-1:0]  fsabo_modes,
  input  logic [NDEV*FSAB_DID_W-1:0]  fsabo_dids,
  input  logic [NDEV*FSAB_DID_W-1:0]  fsabo_subdids,
  input  logic [NDEV*FSAB_ADDR_W-1:0] fsabo_addrs,
  input  logic [NDEV*FSAB_LEN_W-1:0]  fsabo_lens,
  input  logic [NDEV*FSAB_DATA_W-1:0] fsabo_datas,
  input  logic [NDEV*FSAB_MASK_W-1:0] fsabo_masks,
  output logic [NDEV-1:0]             fsabo_credits,
  output logic                        fsabo_valid,
  output logic [FSAB_REQ_W-1:0]       fsabo_mode,
  output logic [FSAB_DID_W-1:0]       fsabo_did,
  output logic [FSAB_DID_W-1:0]       fsabo_subdid,
  output logic [FSAB_ADDR_W-1:0]      fsabo_addr,
  output logic [FSAB_LEN_W-1:0]       fsabo_len,
  output logic [FSAB_DATA_W-1:0]      fsabo_data,
  output logic [FSAB_MASK_W-1:0]      fsabo_mask,
  input  logic                        fsabo_credit,
  output logic [NDEV-1:0]             ovf_err
`ifdef FSAB_ARB_STATS_EN
  ,
  output logic [NDEV*16-1:0]          stat_grants,
  output logic [15:0]                 stat_stalls
`endif
);

  localparam int unsigned IdxW = (NDEV > 1) ? $clog2(NDEV) : 1;
  localparam int unsigned CntW = $clog2(DN_CREDITS + 1);
  localparam logic [IdxW:0]   NdevW   = (IdxW + 1)'(NDEV);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NDEV - 1);
  localparam logic [CntW-1:0] DnMax   = CntW'(DN_CREDITS);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  fsab_beat_t             head [NDEV];
  logic [NDEV-1:0]        empty, pop, elig;
  state_e                 state_q, state_d;
  logic [IdxW-1:0]        grant_q, grant_d, rr_q, rr_d, win;
  logic [IdxW:0]          cand;
  logic                   found, granted;
  logic                   gap_q, gap_d;
  logic [CntW-1:0]        dn_cnt_q, dn_cnt_d;
  logic                   valid_q, valid_d;
  fsab_hdr_t              hdr_q, hdr_d;
  logic [FSAB_DATA_W-1:0] data_q, data_d;
  logic [FSAB_MASK_W-1:0] mask_q, mask_d;
  logic [NDEV-1:0]        credits_q, credits_d;

  for (genvar i = 0; i < NDEV; i++) begin : g_dev
    fsab_hdr_t hdr_in;
    assign hdr_in.mode   = fsabo_modes[i*FSAB_REQ_W +: FSAB_REQ_W];
    assign hdr_in.did    = fsabo_dids[i*FSAB_DID_W +: FSAB_DID_W];
    assign hdr_in.subdid = fsabo_subdids[i*FSAB_DID_W +: FSAB_DID_W];
    assign hdr_in.addr   = fsabo_addrs[i*FSAB_ADDR_W +: FSAB_ADDR_W];
    assign hdr_in.len    = fsabo_lens[i*FSAB_LEN_W +: FSAB_LEN_W];

    fsab_arb_fifo #(
      .Depth(FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .Nrst     (Nrst),
      .wr_valid (fsabo_valids[i]),
      .wr_header(hdr_in),
      .wr_data  (fsabo_datas[i*FSAB_DATA_W +: FSAB_DATA_W]),
      .wr_mask  (fsabo_masks[i*FSAB_MASK_W +: FSAB_MASK_W]),
      .rd_pop   (pop[i]),
      .head     (head[i]),
      .empty    (empty[i]),
      .ovf_err  (ovf_err[i])
    );
  end

  function automatic logic [IdxW-1:0] inc_wrap(input logic [IdxW-1:0] x);
    return (x == LastIdx) ? '0 : x + 1'b1;
  endfunction

  // Round-robin search upward from rr_q over devices whose head starts a packet.
  always_comb begin
    elig  = '0;
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NDEV; i++) elig[i] = !empty[i] && head[i].sof;
    for (int k = 0; k < NDEV; k++) begin
      cand = {1'b0, rr_q} + (IdxW + 1)'(k);
      if (cand >= NdevW) cand = cand - NdevW;
      if (!found && elig[cand[IdxW-1:0]]) begin
        found = 1'b1;
        win   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    gap_d     = 1'b0;
    valid_d   = 1'b0;
    hdr_d     = hdr_q;
    data_d    = data_q;
    mask_d    = mask_q;
    credits_d = '0;
    pop       = '0;
    granted   = 1'b0;
    unique case (state_q)
      StIdle: begin
        hdr_d  = '0;
        data_d = '0;
        mask_d = '0;
        // gap_q forces one idle cycle after every packet end.
        if (found && !gap_q && (dn_cnt_q != '0)) begin
          granted  = 1'b1;
          pop[win] = 1'b1;
          valid_d  = 1'b1;
          hdr_d    = head[win].header;
          data_d   = head[win].data;
          mask_d   = head[win].mask;
          grant_d  = win;
          if (head[win].eof) begin
            credits_d[win] = 1'b1;
            rr_d           = inc_wrap(win);
            gap_d          = 1'b1;
          end else begin
            state_d = StXfer;
          end
        end
      end
      StXfer: begin
        if (!empty[grant_q]) begin
          pop[grant_q] = 1'b1;
          valid_d      = 1'b1;
          data_d       = head[grant_q].data;
          mask_d       = head[grant_q].mask;
          if (head[grant_q].eof) begin
            credits_d[grant_q] = 1'b1;
            rr_d               = inc_wrap(grant_q);
            gap_d              = 1'b1;
            state_d            = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    dn_cnt_d = dn_cnt_q;
    case ({granted, fsabo_credit})
      2'b10:   dn_cnt_d = dn_cnt_q - 1'b1;
      2'b01:   if (dn_cnt_q != DnMax) dn_cnt_d = dn_cnt_q + 1'b1;
      default: dn_cnt_d = dn_cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Nrst) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      rr_q      <= '0;
      gap_q     <= 1'b0;
      dn_cnt_q  <= DnMax;
      valid_q   <= 1'b0;
      hdr_q     <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      credits_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      gap_q     <= gap_d;
      dn_cnt_q  <= dn_cnt_d;
      valid_q   <= valid_d;
      hdr_q     <= hdr_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      credits_q <= credits_d;
    end
  end

  assign fsabo_credits = credits_q;
  assign fsabo_valid   = valid_q;
  assign fsabo_mode    = hdr_q.mode;
  assign fsabo_did     = hdr_q.did;
  assign fsabo_subdid  = hdr_q.subdid;
  assign fsabo_addr    = hdr_q.addr;
  assign fsabo_len     = hdr_q.len;
  assign fsabo_data    = data_q;
  assign fsabo_mask    = mask_q;

`ifdef FSAB_ARB_STATS_EN
  logic [NDEV*16-1:0] stat_grants_q;
  logic [15:0]        stat_stalls_q;

  always_ff @(posedge clk) begin
    if (!Nrst) begin
      stat_grants_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      for (int i = 0; i < NDEV; i++) begin
        if (granted && (win == IdxW'(i))) begin
          stat_grants_q[i*16 +: 16] <= stat_grants_q[i*16 +: 16] + 16'd1;
        end
      end
      if ((|elig) && (dn_cnt_q == '0) && (stat_stalls_q != 16'hffff)) begin
        stat_stalls_q <= stat_stalls_q + 16'd1;
      end
    end
  end

  assign stat_grants = stat_grants_q;
  assign stat_stalls = stat_stalls_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
